// File: rtl/pmem_loader.sv
// Program-memory loader: receives a framed byte stream, writes 16-bit pmem words and keeps the CPU in reset until the checksum verifies.
// Optional PMEM_LOADER_TIMEOUT_EN aborts a frame after TIMEOUT_CYCLES idle cycles mid-frame.
module pmem_loader #(
  parameter int          ADDR_W         = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state, state_d;
  logic [15:0]       count, count_d;
  logic [7:0]        csum, csum_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       wdata_d;
  logic              cpu_reset_d, done_d, error_d;
  logic              fire;
  logic [16:0]       len;

  assign in_ready = (state != WRITE);
  assign mem_we   = (state == WRITE);
  assign fire     = in_valid && in_ready;
  assign len      = {1'b0, in_data, count[7:0]};

`ifdef PMEM_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic            mid, to_hit;

  assign mid    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA_LO) ||
                  (state == DATA_HI) || (state == CHECK);
  assign to_hit = mid && !fire && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (mid && !fire && !to_hit) to_cnt_d = to_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) to_cnt <= '0;
    else        to_cnt <= to_cnt_d;
  end
`endif

  always_comb begin
    state_d     = state;
    count_d     = count;
    csum_d      = csum;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    cpu_reset_d = cpu_reset;
    done_d      = done;
    error_d     = error;
    case (state)
      IDLE, DONE, ERROR: begin
        if (fire && in_data == SYNC_BYTE) begin
          state_d     = LEN_LO;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          addr_d      = '0;
          csum_d      = '0;
        end
      end
      LEN_LO: if (fire) begin
        count_d[7:0] = in_data;
        state_d      = LEN_HI;
      end
      LEN_HI: if (fire) begin
        count_d[15:8] = in_data;
        if (len > CAP) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else if (len == 17'd0) begin
          state_d = CHECK;
        end else begin
          state_d = DATA_LO;
        end
      end
      DATA_LO: if (fire) begin
        wdata_d[7:0] = in_data;
        csum_d       = csum + in_data;
        state_d      = DATA_HI;
      end
      DATA_HI: if (fire) begin
        wdata_d[15:8] = in_data;
        csum_d        = csum + in_data;
        state_d       = WRITE;
      end
      WRITE: begin
        // address wraps to 0 on a full-capacity frame; harmless since we go to CHECK
        addr_d  = mem_addr + 1'b1;
        count_d = count - 16'd1;
        state_d = (count == 16'd1) ? CHECK : DATA_LO;
      end
      CHECK: if (fire) begin
        if (in_data == csum) begin
          state_d     = DONE;
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
        end else begin
          state_d = ERROR;
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PMEM_LOADER_TIMEOUT_EN
    if (to_hit) begin
      state_d     = ERROR;
      error_d     = 1'b1;
      cpu_reset_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      csum      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      csum      <= csum_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      cpu_reset <= cpu_reset_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboard bench for pmem_loader: driver queues expected pmem writes, a negedge monitor pops and compares them.
module tb_pmem_loader;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, cpu_reset, done, error;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] bq[$];
  int         tests = 0;
  int         errors = 0;

  pmem_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clock) begin
    if (reset && mem_we) begin
      wr_t e;
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int guard;
    @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      tests++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_q();
    foreach (bq[i]) send(bq[i]);
  endtask

  task automatic status(input string name, input logic d, input logic e, input logic cr);
    @(negedge clock);
    check({name, "_done"}, {31'd0, done}, {31'd0, d});
    check({name, "_error"}, {31'd0, error}, {31'd0, e});
    check({name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
  endtask

  task automatic reset_vals(input string name);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({name, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #22;
    reset_vals("por");
    @(negedge clock);
    reset = 1'b1;

    // two-word frame, good checksum 13+05+93+05 = B0
    exp_q.push_back('{addr: 10'd0, data: 16'h0513});
    exp_q.push_back('{addr: 10'd1, data: 16'h0593});
    bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h93, 8'h05, 8'hB0};
    send_q();
    status("good", 1'b1, 1'b0, 1'b0);

    // same frame, bad checksum
    exp_q.push_back('{addr: 10'd0, data: 16'h0513});
    exp_q.push_back('{addr: 10'd1, data: 16'h0593});
    bq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h93, 8'h05, 8'hF6};
    send_q();
    status("badsum", 1'b0, 1'b1, 1'b1);

    // leading junk ignored, empty frame
    bq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    status("empty", 1'b1, 1'b0, 1'b0);

    // LEN = 1025 exceeds capacity
    bq = '{8'hA5, 8'h01, 8'h04};
    send_q();
    status("toolong", 1'b0, 1'b1, 1'b1);
    bq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    status("recover", 1'b1, 1'b0, 1'b0);

    // async reset between hi byte and the write cycle
    bq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_q();
    reset = 1'b0;
    #1 reset_vals("midrst");
    @(negedge clock);
    check("midrst_mem_we_held", {31'd0, mem_we}, 32'd0);
    reset = 1'b1;

    // back-to-back frames, in-frame A5 is data
    bq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    status("b2b_first", 1'b1, 1'b0, 1'b0);
    send(8'hA5);
    status("b2b_sync", 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{addr: 10'd0, data: 16'h00A5});
    bq = '{8'h01, 8'h00, 8'hA5, 8'h00, 8'hA5};
    send_q();
    status("b2b_second", 1'b1, 1'b0, 1'b0);

    // stall after LEN_LO
    bq = '{8'hA5, 8'h01};
    send_q();
    repeat (20) @(negedge clock);
`ifdef PMEM_LOADER_TIMEOUT_EN
    status("stall", 1'b0, 1'b1, 1'b1);
    bq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    status("stall_recover", 1'b1, 1'b0, 1'b0);
`else
    status("stall", 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{addr: 10'd0, data: 16'h1234});
    bq = '{8'h00, 8'h34, 8'h12, 8'h46};
    send_q();
    status("stall_resume", 1'b1, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clock);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
